// File: rtl/lpc_host_io.sv
// LPC host for single-byte I/O read/write cycles: serialises START/CYCTYPE/ADDR/DATA/TAR,
// decodes the target's SYNC (ready, short/long wait, error), and aborts on timeout.
module lpc_host_io #(
  parameter int unsigned SYNC_TIMEOUT = 3,
  parameter int unsigned LWAIT_MAX    = 1024
) (
  input  logic        lclk,
  input  logic        lreset_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        lframe_n,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic [3:0]  lad_in
);

  localparam int unsigned TO_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned LW_W = $clog2(LWAIT_MAX + 1);

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR = 4'b1010;

  // Each state names the action taken at the clock edge where it is current.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR, S_WDATA, S_TAR1, S_TAR2,
    S_SYNC, S_RDATA, S_PTAR, S_ABORT, S_ABORT_END, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [LW_W-1:0] lw_q, lw_d;
  logic            we_q, we_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rbuf_q, rbuf_d;
  logic            serr_q, serr_d;
  logic            abort_q, abort_d;
  logic            busy_d, done_d, err_d, lframe_n_d, lad_oe_d;
  logic [7:0]      rdata_d;
  logic [3:0]      lad_out_d;

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      to_q     <= '0;
      lw_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      rbuf_q   <= 8'h00;
      serr_q   <= 1'b0;
      abort_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 8'h00;
      lframe_n <= 1'b1;
      lad_out  <= 4'hF;
      lad_oe   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      lw_q     <= lw_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      serr_q   <= serr_d;
      abort_q  <= abort_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      rdata    <= rdata_d;
      lframe_n <= lframe_n_d;
      lad_out  <= lad_out_d;
      lad_oe   <= lad_oe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    lw_d       = lw_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    serr_d     = serr_q;
    abort_d    = abort_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;
    rdata_d    = rdata;
    lframe_n_d = 1'b1;
    lad_out_d  = 4'hF;
    lad_oe_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = 2'd0;
          to_d    = '0;
          lw_d    = '0;
          serr_d  = 1'b0;
          abort_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        lframe_n_d = 1'b0;
        lad_out_d  = 4'h0;
        lad_oe_d   = 1'b1;
        state_d    = S_CYCTYPE;
      end
      S_CYCTYPE: begin
        lad_out_d = we_q ? 4'b0010 : 4'b0000;
        lad_oe_d  = 1'b1;
        cnt_d     = 2'd0;
        state_d   = S_ADDR;
      end
      S_ADDR: begin
        lad_oe_d = 1'b1;
        case (cnt_q)
          2'd0:    lad_out_d = addr_q[15:12];
          2'd1:    lad_out_d = addr_q[11:8];
          2'd2:    lad_out_d = addr_q[7:4];
          default: lad_out_d = addr_q[3:0];
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = we_q ? S_WDATA : S_TAR1;
        end
      end
      S_WDATA: begin
        lad_oe_d  = 1'b1;
        lad_out_d = (cnt_q == 2'd0) ? wdata_q[3:0] : wdata_q[7:4];
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          cnt_d   = 2'd0;
          state_d = S_TAR1;
        end
      end
      S_TAR1: begin
        lad_oe_d = 1'b1;
        state_d  = S_TAR2;
      end
      S_TAR2: state_d = S_SYNC;
      S_SYNC: begin
        // Short waits stall without counting; only invalid nibbles feed the timeout.
        case (lad_in)
          SYNC_READY, SYNC_ERROR: begin
            to_d    = '0;
            lw_d    = '0;
            serr_d  = (lad_in == SYNC_ERROR);
            cnt_d   = 2'd0;
            state_d = we_q ? S_PTAR : S_RDATA;
          end
          SYNC_SHORT: state_d = S_SYNC;
          SYNC_LONG: begin
            if (lw_q == LW_W'(LWAIT_MAX - 1)) begin
              cnt_d   = 2'd0;
              state_d = S_ABORT;
            end else begin
              lw_d = lw_q + LW_W'(1);
            end
          end
          default: begin
            if (to_q == TO_W'(SYNC_TIMEOUT - 1)) begin
              cnt_d   = 2'd0;
              state_d = S_ABORT;
            end else begin
              to_d = to_q + TO_W'(1);
            end
          end
        endcase
      end
      S_RDATA: begin
        if (cnt_q == 2'd0) begin
          rbuf_d[3:0] = lad_in;
          cnt_d       = 2'd1;
        end else begin
          rbuf_d[7:4] = lad_in;
          cnt_d       = 2'd0;
          state_d     = S_PTAR;
        end
      end
      S_PTAR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          cnt_d   = 2'd0;
          state_d = S_DONE;
        end
      end
      S_ABORT: begin
        lframe_n_d = 1'b0;
        lad_oe_d   = 1'b1;
        abort_d    = 1'b1;
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = S_ABORT_END;
        end
      end
      S_ABORT_END: state_d = S_DONE;
      S_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        err_d  = serr_q | abort_q;
        if (!we_q) rdata_d = abort_q ? 8'hFF : rbuf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lpc_host_io.sv
// Directed bench for lpc_host_io: write/read cycles, SYNC waits, error SYNC, abort,
// mid-cycle reset and req-while-busy.
module tb_lpc_host_io;

  logic        lclk = 1'b0;
  logic        lreset_n;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic        lframe_n;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic [3:0]  lad_in;

  int checks = 0;
  int errors = 0;

  logic [3:0] resp   [0:31];
  logic [3:0] lad_h  [0:31];
  logic       oe_h   [0:31];
  logic       lf_h   [0:31];
  logic       busy_h [0:31];
  int         done_cyc;
  logic [7:0] rd_o;
  logic       err_o;

  lpc_host_io dut (
    .lclk(lclk), .lreset_n(lreset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .lframe_n(lframe_n),
    .lad_out(lad_out), .lad_oe(lad_oe), .lad_in(lad_in)
  );

  always #5 lclk = ~lclk;

  task automatic tick();
    @(posedge lclk);
    #1;
  endtask

  task automatic clear_resp();
    for (int i = 0; i < 32; i++) resp[i] = 4'hF;
  endtask

  task automatic record(input int k);
    lad_h[k]  = lad_out;
    oe_h[k]   = lad_oe;
    lf_h[k]   = lframe_n;
    busy_h[k] = busy;
  endtask

  // Issues one request and plays resp[k] on lad_in ahead of edge k; optional req pulses.
  task automatic run_xfer(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input int pulse_a, input int pulse_b);
    done_cyc = -1;
    rd_o     = 8'hxx;
    err_o    = 1'bx;
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0;
    record(0);
    for (int k = 1; k < 32; k++) begin
      lad_in = resp[k];
      if (k == pulse_a || k == pulse_b) begin
        req = 1'b1; we = ~w; addr = 16'h1234; wdata = 8'hEE;
      end
      tick();
      req = 1'b0;
      record(k);
      if (done) begin
        done_cyc = k;
        rd_o     = rdata;
        err_o    = err;
        break;
      end
    end
    lad_in = 4'hF;
  endtask

  task automatic test_reset();
    lreset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; lad_in = 4'hF;
    #12;
    checks++;
    if ({busy, done, err, rdata, lframe_n, lad_out, lad_oe} !== {3'b000, 8'h00, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b err=%b rdata=%h lframe_n=%b lad=%h oe=%b",
               busy, done, err, rdata, lframe_n, lad_out, lad_oe);
    end
    @(negedge lclk);
    lreset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_ready();
    logic [3:0] exp [9];
    exp = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'h5, 4'hF};
    clear_resp();
    resp[11] = 4'h0;
    run_xfer(1'b1, 16'h0080, 8'h55, -1, -1);
    checks++;
    if (busy_h[0] !== 1'b1) begin errors++; $display("FAIL wr_busy0: got %b want 1", busy_h[0]); end
    checks++;
    if (lf_h[1] !== 1'b0 || lf_h[2] !== 1'b1) begin
      errors++; $display("FAIL wr_lframe: got c1=%b c2=%b want 0,1", lf_h[1], lf_h[2]);
    end
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (lad_h[k] !== exp[k-1] || oe_h[k] !== 1'b1) begin
        errors++; $display("FAIL wr_lad_c%0d: got lad=%h oe=%b want %h,1", k, lad_h[k], oe_h[k], exp[k-1]);
      end
    end
    checks++;
    if (oe_h[10] !== 1'b0) begin errors++; $display("FAIL wr_tar2_oe: got %b want 0", oe_h[10]); end
    checks++;
    if (done_cyc != 14 || err_o !== 1'b0) begin
      errors++; $display("FAIL wr_done: got cycle=%0d err=%b want 14,0", done_cyc, err_o);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_read_short_wait();
    logic [3:0] exp [4];
    exp = '{4'h0, 4'h3, 4'hF, 4'h8};
    clear_resp();
    resp[9] = 4'h5; resp[10] = 4'h5; resp[11] = 4'h0; resp[12] = 4'h5; resp[13] = 4'hA;
    run_xfer(1'b0, 16'h03F8, 8'h00, -1, -1);
    checks++;
    if (lad_h[2] !== 4'h0) begin errors++; $display("FAIL rd_cyctype: got %h want 0", lad_h[2]); end
    for (int k = 3; k <= 6; k++) begin
      checks++;
      if (lad_h[k] !== exp[k-3]) begin
        errors++; $display("FAIL rd_addr_c%0d: got %h want %h", k, lad_h[k], exp[k-3]);
      end
    end
    checks++;
    if (oe_h[7] !== 1'b1 || lad_h[7] !== 4'hF || oe_h[8] !== 1'b0) begin
      errors++; $display("FAIL rd_tar: got c7 oe=%b lad=%h c8 oe=%b want 1,F,0", oe_h[7], lad_h[7], oe_h[8]);
    end
    checks++;
    if (done_cyc != 16 || rd_o !== 8'hA5 || err_o !== 1'b0) begin
      errors++; $display("FAIL rd_wait_done: got cycle=%0d rdata=%h err=%b want 16,A5,0", done_cyc, rd_o, err_o);
    end
  endtask

  task automatic test_read_abort();
    int lows;
    clear_resp();
    run_xfer(1'b0, 16'h03F9, 8'h00, -1, -1);
    lows = 0;
    for (int k = 9; k <= 16; k++) if (lf_h[k] === 1'b0) lows++;
    checks++;
    if (lows != 4 || lf_h[12] !== 1'b0 || lf_h[15] !== 1'b0) begin
      errors++; $display("FAIL abort_lframe: got low_clocks=%0d c12=%b c15=%b want 4,0,0", lows, lf_h[12], lf_h[15]);
    end
    checks++;
    if (oe_h[12] !== 1'b1 || lad_h[12] !== 4'hF || oe_h[16] !== 1'b0 || lf_h[16] !== 1'b1) begin
      errors++; $display("FAIL abort_drive: got c12 oe=%b lad=%h c16 oe=%b lf=%b want 1,F,0,1",
                         oe_h[12], lad_h[12], oe_h[16], lf_h[16]);
    end
    checks++;
    if (done_cyc != 17 || err_o !== 1'b1 || rd_o !== 8'hFF) begin
      errors++; $display("FAIL abort_done: got cycle=%0d err=%b rdata=%h want 17,1,FF", done_cyc, err_o, rd_o);
    end
  endtask

  task automatic test_write_sync_error();
    clear_resp();
    resp[11] = 4'hA;
    run_xfer(1'b1, 16'h03FA, 8'h3C, -1, -1);
    checks++;
    if (done_cyc != 14 || err_o !== 1'b1) begin
      errors++; $display("FAIL wr_err_done: got cycle=%0d err=%b want 14,1", done_cyc, err_o);
    end
    checks++;
    if (rd_o !== 8'hFF) begin errors++; $display("FAIL wr_err_rdata_hold: got %h want FF", rd_o); end
  endtask

  task automatic test_reset_mid_cycle();
    int ndone;
    req = 1'b1; we = 1'b1; addr = 16'h0080; wdata = 8'h99;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #2 lreset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, rdata, lframe_n, lad_out, lad_oe} !== {3'b000, 8'h00, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values: got busy=%b done=%b err=%b rdata=%h lframe_n=%b lad=%h oe=%b",
               busy, done, err, rdata, lframe_n, lad_out, lad_oe);
    end
    tick(); tick();
    lreset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL midreset_no_done: got %0d active clocks want 0", ndone); end
    clear_resp();
    resp[9] = 4'h0; resp[10] = 4'h3; resp[11] = 4'hC;
    run_xfer(1'b0, 16'h0080, 8'h00, -1, -1);
    checks++;
    if (done_cyc != 14 || rd_o !== 8'hC3 || err_o !== 1'b0) begin
      errors++; $display("FAIL midreset_next: got cycle=%0d rdata=%h err=%b want 14,C3,0", done_cyc, rd_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp [6];
    int extra;
    exp = '{4'h0, 4'h3, 4'hF, 4'hF, 4'h2, 4'h1};
    clear_resp();
    resp[11] = 4'h0;
    run_xfer(1'b1, 16'h03FF, 8'h12, 5, 14);
    for (int k = 3; k <= 8; k++) begin
      checks++;
      if (lad_h[k] !== exp[k-3]) begin
        errors++; $display("FAIL busy_req_lad_c%0d: got %h want %h", k, lad_h[k], exp[k-3]);
      end
    end
    checks++;
    if (done_cyc != 14 || err_o !== 1'b0) begin
      errors++; $display("FAIL busy_req_done: got cycle=%0d err=%b want 14,0", done_cyc, err_o);
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1 || lframe_n === 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_req_not_queued: got %0d active clocks want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_write_ready();
    test_read_short_wait();
    test_read_abort();
    test_write_sync_error();
    test_reset_mid_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
